// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and parameter limits for the unified memory arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_M} owner_t;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  function automatic logic lat_ok(input int lat);
    return lat >= LAT_MIN && lat <= LAT_MAX;
  endfunction
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable 4-bit down-counter, expire while the count sits at zero
module mem_arb_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expire
);
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  end
  assign expire = cnt_q == 4'd0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between IF fetches and M loads/stores
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_done,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  if (!lat_ok(LATENCY) || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_arbiter: LATENCY must be 1..15 and STARVE_MAX at least 1");
  end
  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic we_q, we_d;
  logic [SW-1:0] starve_q, starve_d;
  logic m_win, issue, fin, expire;
  always_comb begin
    m_win    = m_req & ~(if_req & (starve_q == SMAX));
    issue    = ~rst & (state_q == IDLE) & (if_req | m_req);
    fin      = (state_q == BUSY) & (we_q | expire);
    state_d  = fin ? IDLE : issue ? BUSY : state_q;
    owner_d  = fin ? OWN_NONE : issue ? (m_win ? OWN_M : OWN_IF) : owner_q;
    we_d     = fin ? 1'b0 : issue ? (m_win & m_we) : we_q;
    starve_d = !issue ? starve_q : !m_win ? '0 :
               (if_req && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end
  mem_arb_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (issue),
    .load_val (4'(LATENCY - 1)),
    .expire   (expire)
  );
  // Issue is combinational in IDLE; every output is forced low while rst is held
  assign mem_en    = issue;
  assign mem_we    = issue & m_win & m_we;
  assign mem_addr  = issue ? (m_win ? m_addr : if_addr) : '0;
  assign mem_wdata = (issue & m_win) ? m_wdata : '0;
  assign if_done   = fin & (owner_q == OWN_IF);
  assign m_done    = fin & (owner_q == OWN_M);
  assign if_rdata  = if_done ? mem_rdata : '0;
  assign m_rdata   = (m_done & ~we_q) ? mem_rdata : '0;
  assign if_stall  = ~rst & if_req & ~if_done;
  assign m_stall   = ~rst & m_req & ~m_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic if_req, m_req, m_we, if_done, if_stall, m_done, m_stall, mem_en, mem_we;
  logic [15:0] if_addr, m_addr, mem_addr;
  logic [31:0] m_wdata, if_rdata, m_rdata, mem_wdata, mem_rdata;
  logic if_req1, m_req1, m_we1, if_done1, if_stall1, m_done1, m_stall1, mem_en1, mem_we1;
  logic [15:0] if_addr1, m_addr1, mem_addr1;
  logic [31:0] m_wdata1, if_rdata1, m_rdata1, mem_wdata1, mem_rdata1;
  int n_cmp = 0, n_bad = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .LATENCY(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata), .m_stall(m_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .LATENCY(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1),
    .if_rdata(if_rdata1), .if_stall(if_stall1), .m_req(m_req1), .m_we(m_we1), .m_addr(m_addr1),
    .m_wdata(m_wdata1), .m_done(m_done1), .m_rdata(m_rdata1), .m_stall(m_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1));

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {~a, a};
  endfunction
  function automatic logic [15:0] ra();
    return 16'h1000 + 16'($urandom_range(0, 15) * 4);
  endfunction

  // Memory macro models: write commits at the issue edge, read data appears LATENCY cycles later
  logic [31:0] mem [4096];
  logic [31:0] pipe [LAT];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[13:2]] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[13:2]] : 32'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    rd1 <= (mem_en1 && !mem_we1) ? pat(mem_addr1) : 32'h0;
  end
  assign mem_rdata = pipe[LAT-1];
  assign mem_rdata1 = rd1;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; m_req = 1'b1; m_we = 1'b1; if_addr = 16'h0010;
    m_addr = 16'h0020; m_wdata = 32'h1234_5678; if_req1 = 1'b1; if_addr1 = 16'h0010;
    smp;
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, if_done, if_rdata, if_stall, m_done, m_rdata, m_stall} !== '0) begin
      n_bad++; $display("FAIL reset_outs: got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata, if_done, if_rdata, if_stall, m_done, m_rdata, m_stall});
    end
    n_cmp++;
    if ({mem_en1, mem_we1, mem_addr1, mem_wdata1, if_done1, if_rdata1, if_stall1, m_done1, m_rdata1, m_stall1} !== '0) begin
      n_bad++; $display("FAIL reset_outs1: got %h want 0", {mem_en1, mem_we1, mem_addr1, mem_wdata1, if_done1, if_rdata1, if_stall1, m_done1, m_rdata1, m_stall1});
    end
    nxt; if_req = 1'b0; m_req = 1'b0; m_we = 1'b0; if_req1 = 1'b0;
    nxt; rst = 1'b0;
    nxt;
  endtask

  task automatic test_solo_if;
    nxt; if_req = 1'b1; if_addr = 16'h0010;
    smp;
    n_cmp++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0010}) begin n_bad++; $display("FAIL solo_issue: got %h want %h", {mem_en, mem_we, mem_addr}, {2'b10, 16'h0010}); end
    n_cmp++; if ({if_stall, if_done} !== 2'b10) begin n_bad++; $display("FAIL solo_c0_stall: got %b want 10", {if_stall, if_done}); end
    nxt; smp;
    n_cmp++; if ({mem_en, if_stall, if_done} !== 3'b010) begin n_bad++; $display("FAIL solo_c1: got %b want 010", {mem_en, if_stall, if_done}); end
    nxt; smp;
    n_cmp++; if ({if_done, if_stall} !== 2'b10) begin n_bad++; $display("FAIL solo_done: got %b want 10", {if_done, if_stall}); end
    n_cmp++; if (if_rdata !== pat(16'h0010)) begin n_bad++; $display("FAIL solo_rdata: got %h want %h", if_rdata, pat(16'h0010)); end
    nxt; if_req = 1'b0; smp;
    n_cmp++; if ({if_done, if_rdata} !== '0) begin n_bad++; $display("FAIL solo_after: got %h want 0", {if_done, if_rdata}); end
  endtask

  task automatic test_contention;
    nxt; if_req = 1'b1; if_addr = 16'h0020; m_req = 1'b1; m_we = 1'b0; m_addr = 16'h0100;
    smp;
    n_cmp++; if ({mem_en, mem_addr, if_stall, m_stall} !== {1'b1, 16'h0100, 2'b11}) begin n_bad++; $display("FAIL cont_m_issue: got %h want %h", {mem_en, mem_addr, if_stall, m_stall}, {1'b1, 16'h0100, 2'b11}); end
    nxt; smp;
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL cont_c1_en: got %b want 0", mem_en); end
    nxt; smp;
    n_cmp++; if ({m_done, if_stall, mem_en} !== 3'b110) begin n_bad++; $display("FAIL cont_m_done: got %b want 110", {m_done, if_stall, mem_en}); end
    n_cmp++; if (m_rdata !== pat(16'h0100)) begin n_bad++; $display("FAIL cont_m_rdata: got %h want %h", m_rdata, pat(16'h0100)); end
    nxt; m_req = 1'b0; smp;
    n_cmp++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0020}) begin n_bad++; $display("FAIL cont_if_issue: got %h want %h", {mem_en, mem_we, mem_addr}, {2'b10, 16'h0020}); end
    nxt; nxt; smp;
    n_cmp++; if ({if_done, m_done} !== 2'b10) begin n_bad++; $display("FAIL cont_if_done: got %b want 10", {if_done, m_done}); end
    n_cmp++; if (if_rdata !== pat(16'h0020)) begin n_bad++; $display("FAIL cont_if_rdata: got %h want %h", if_rdata, pat(16'h0020)); end
    nxt; if_req = 1'b0;
  endtask

  task automatic test_store_load;
    nxt; m_req = 1'b1; m_we = 1'b1; m_addr = 16'h0040; m_wdata = 32'hDEAD_BEEF;
    smp;
    n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0040, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL st_issue: got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0040, 32'hDEAD_BEEF}); end
    nxt; smp;
    n_cmp++; if ({m_done, m_stall, mem_en} !== 3'b100) begin n_bad++; $display("FAIL st_done: got %b want 100", {m_done, m_stall, mem_en}); end
    nxt; m_we = 1'b0; smp;
    n_cmp++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0040}) begin n_bad++; $display("FAIL ld_issue: got %h want %h", {mem_en, mem_we, mem_addr}, {2'b10, 16'h0040}); end
    nxt; nxt; smp;
    n_cmp++; if ({m_done, m_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL ld_rdata: got %h want %h", {m_done, m_rdata}, {1'b1, 32'hDEAD_BEEF}); end
    nxt; m_req = 1'b0;
  endtask

  task automatic test_starvation;
    logic [5:0] seq = '0;
    int got = 0;
    nxt; if_req = 1'b1; if_addr = 16'h0080; m_req = 1'b1; m_we = 1'b0; m_addr = 16'h0200;
    for (int i = 0; i < 60; i++) begin
      smp;
      if (mem_en && got < 6) begin seq[got] = mem_addr == 16'h0200; got++; end
      if (got >= 6 && (if_done || m_done)) break;
      nxt;
    end
    nxt; if_req = 1'b0; m_req = 1'b0;
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL starve_timeout: got %0d grants want 6", got); end
    n_cmp++; if (seq !== 6'b101111) begin n_bad++; $display("FAIL starve_order: got %b want 101111 (bit=1 M grant, LSB first)", seq); end
  endtask

  task automatic test_reset_mid_busy;
    nxt; if_req = 1'b1; if_addr = 16'h0030;
    smp;
    n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL rmb_issue: got %b want 1", mem_en); end
    nxt; rst = 1'b1; smp;
    n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata, if_done, if_rdata, if_stall, m_done, m_rdata, m_stall} !== '0) begin n_bad++; $display("FAIL rmb_outs: got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata, if_done, if_rdata, if_stall, m_done, m_rdata, m_stall}); end
    nxt; rst = 1'b0; smp;
    n_cmp++; if ({if_done, mem_en, mem_addr} !== {2'b01, 16'h0030}) begin n_bad++; $display("FAIL rmb_reissue: got %h want %h", {if_done, mem_en, mem_addr}, {2'b01, 16'h0030}); end
    nxt; smp;
    n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL rmb_no_done: got %b want 0", if_done); end
    nxt; smp;
    n_cmp++; if ({if_done, if_rdata} !== {1'b1, pat(16'h0030)}) begin n_bad++; $display("FAIL rmb_done: got %h want %h", {if_done, if_rdata}, {1'b1, pat(16'h0030)}); end
    nxt; if_req = 1'b0;
  endtask

  task automatic test_lat1;
    logic [15:0] a;
    nxt; if_req1 = 1'b1; if_addr1 = 16'h0100;
    for (int c = 0; c < 8; c++) begin
      smp;
      a = 16'h0100 + 16'((c / 2) * 4);
      n_cmp++; if ({mem_en1, if_done1, m_done1} !== {c % 2 == 0, c % 2 == 1, 1'b0}) begin n_bad++; $display("FAIL lat1_c%0d: got en/done/mdone %b want %b", c, {mem_en1, if_done1, m_done1}, {c % 2 == 0, c % 2 == 1, 1'b0}); end
      if (c % 2 == 0) begin
        n_cmp++; if ({mem_addr1, if_stall1} !== {a, 1'b1}) begin n_bad++; $display("FAIL lat1_issue_c%0d: got %h want %h", c, {mem_addr1, if_stall1}, {a, 1'b1}); end
      end else begin
        n_cmp++; if (if_rdata1 !== pat(a)) begin n_bad++; $display("FAIL lat1_rdata_c%0d: got %h want %h", c, if_rdata1, pat(a)); end
      end
      nxt;
      if (c % 2 == 1) if_addr1 = if_addr1 + 16'd4;
    end
    if_req1 = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [31:0] sh [16];
    logic [31:0] exp_d = '0;
    logic [15:0] a;
    logic busy = 1'b0, wr = 1'b0, mw, e_if, e_m, e_en;
    int own = 0, done_at = 0, sc = 0;
    for (int i = 0; i < 16; i++) sh[i] = pat(16'h1000 + 16'(i * 4));
    nxt; rst = 1'b1; if_req = 1'b0; m_req = 1'b0;
    nxt; rst = 1'b0;
    for (int c = 0; c < n; c++) begin
      smp;
      e_if = 1'b0; e_m = 1'b0; e_en = 1'b0;
      if (busy && c == done_at) begin
        e_if = own == 1; e_m = own == 2; busy = 1'b0;
      end else if (!busy && (if_req || m_req)) begin
        mw = m_req && !(if_req && sc == SMAX);
        a = mw ? m_addr : if_addr;
        wr = mw && m_we;
        e_en = 1'b1;
        n_cmp++; if ({mem_addr, mem_we} !== {a, wr}) begin n_bad++; $display("FAIL rnd_issue c%0d: got %h want %h", c, {mem_addr, mem_we}, {a, wr}); end
        if (wr) begin
          n_cmp++; if (mem_wdata !== m_wdata) begin n_bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, m_wdata); end
          sh[a[5:2]] = m_wdata;
        end else exp_d = sh[a[5:2]];
        busy = 1'b1; own = mw ? 2 : 1; done_at = c + (wr ? 1 : LAT);
        sc = !mw ? 0 : (if_req && sc < SMAX) ? sc + 1 : sc;
      end
      n_cmp++; if ({mem_en, if_done, m_done} !== {e_en, e_if, e_m}) begin n_bad++; $display("FAIL rnd_ctl c%0d: got en/ifd/md %b want %b", c, {mem_en, if_done, m_done}, {e_en, e_if, e_m}); end
      n_cmp++; if ({if_stall, m_stall} !== {if_req & ~e_if, m_req & ~e_m}) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, {if_stall, m_stall}, {if_req & ~e_if, m_req & ~e_m}); end
      n_cmp++; if (if_rdata !== (e_if ? exp_d : 32'h0)) begin n_bad++; $display("FAIL rnd_if_rdata c%0d: got %h want %h", c, if_rdata, e_if ? exp_d : 32'h0); end
      if (!(e_m && wr)) begin
        n_cmp++; if (m_rdata !== (e_m ? exp_d : 32'h0)) begin n_bad++; $display("FAIL rnd_m_rdata c%0d: got %h want %h", c, m_rdata, e_m ? exp_d : 32'h0); end
      end
      nxt;
      if (e_if) if_req = 1'b0;
      if (e_m) m_req = 1'b0;
      if (c < n - 40) begin
        if (!if_req && $urandom_range(0, 2) != 0) begin if_req = 1'b1; if_addr = ra(); end
        if (!m_req && $urandom_range(0, 2) != 0) begin
          m_req = 1'b1; m_we = 1'($urandom_range(0, 1)); m_addr = ra(); m_wdata = $urandom;
        end
      end
    end
    n_cmp++; if ({busy, if_req, m_req} !== 3'b000) begin n_bad++; $display("FAIL rnd_drain: got busy/ifr/mr %b want 000", {busy, if_req, m_req}); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = pat(16'(i * 4));
    if_req = 1'b0; m_req = 1'b0; m_we = 1'b0; if_addr = '0; m_addr = '0; m_wdata = '0;
    if_req1 = 1'b0; m_req1 = 1'b0; m_we1 = 1'b0; if_addr1 = '0; m_addr1 = '0; m_wdata1 = '0;
    nxt; nxt;
    test_reset;
    test_solo_if;
    test_contention;
    test_store_load;
    test_starvation;
    test_reset_mid_busy;
    test_lat1;
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
